pc_sequencer: RTL and testbench

//  Owns the fetch PC register of the 5-stage pipeline and sequences every PC update.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_npc_calc.sv | 43 ++++
 rtl/pc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared encodings for the fetch PC sequencer:
//   - NPC_* : next-PC operation codes carried by the EX-stage instruction
//   - pcs_state_e : PC sequencer FSM state codes (also exported on state_o)
//   - npc_is_redirect() : true for the ops that leave the sequential path
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    PCS_RUN   = 2'd0,
    PCS_WAIT  = 2'd1,
    PCS_STALL = 2'd2,
    PCS_REDIR = 2'd3
  } pcs_state_e;

  function automatic logic npc_is_redirect(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// ---------------------------------------------------------------------------
// pc_sequencer_npc_calc
//   Pure combinational next-PC target calculator.
//   Ports:
//     i_pc       in  32  current fetch PC (base for PLUS4)
//     i_npcop    in  3   NPC op of the EX instruction
//     i_ex_pc    in  32  EX instruction PC (branch/jump base)
//     i_ex_imm   in  32  EX sign-extended immediate
//     i_ex_alu   in  32  ALU result (jalr target)
//     o_target   out 32  word-aligned target (bits[1:0] = 0)
//     o_redirect out 1   op leaves the sequential path
//     o_misalign out 1   redirect whose unmasked target had bit[1] set
// ---------------------------------------------------------------------------
module pc_sequencer_npc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_npcop,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_imm,
  input  logic [31:0] i_ex_alu,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_misalign
);

  logic [31:0] w_raw;

  // Unknown op codes fall through to the sequential path.
  always_comb begin
    w_raw = i_pc + 32'd4;
    unique case (i_npcop)
      NPC_BRANCH, NPC_JUMP: w_raw = i_ex_pc + i_ex_imm;
      NPC_JALR:             w_raw = {i_ex_alu[31:1], 1'b0};
      default:              w_raw = i_pc + 32'd4;
    endcase
  end

  assign o_redirect = npc_is_redirect(i_npcop);
  assign o_target   = {w_raw[31:2], 2'b00};
  assign o_misalign = o_redirect & w_raw[1];

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Owns the fetch PC and sequences every PC update: sequential fetch,
//   EX-stage redirects, hazard stalls and imem wait states. Emits IF/ID and
//   ID/EX flush pulses for the wrong-path slots after a redirect.
//   Ports:
//     clk          in  1   clock, rising edge
//     rstn         in  1   asynchronous active-low reset
//     stall_i      in  1   hazard stall: freeze PC
//     imem_rdy_i   in  1   imem delivered the word at pc_o this cycle
//     ex_npcop_i   in  3   NPC op of the EX instruction
//     ex_pc_i      in  32  EX instruction PC
//     ex_imm_i     in  32  EX immediate
//     ex_alu_i     in  32  ALU result (jalr)
//     pc_o         out 32  fetch address
//     fetch_en_o   out 1   pc_o is a valid fetch request
//     flush_ifid_o out 1   squash IF/ID next edge
//     flush_idex_o out 1   squash ID/EX next edge
//     misalign_o   out 1   sticky misaligned-redirect flag
//     state_o      out 2   FSM state for trace
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          KILL_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic        imem_rdy_i,
  input  logic [2:0]  ex_npcop_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_alu_i,
  output logic [31:0] pc_o,
  output logic        fetch_en_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic        misalign_o,
  output logic [1:0]  state_o
);

  localparam int KW = (KILL_DEPTH > 2) ? $clog2(KILL_DEPTH) : 1;
  localparam logic [KW-1:0] KILL_LOAD = KW'(KILL_DEPTH - 1);
  // With a single kill slot the redirect cycle's own flush is enough.
  localparam pcs_state_e AFTER_TAKE = (KILL_DEPTH > 1) ? PCS_REDIR : PCS_RUN;

  pcs_state_e    r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [KW-1:0] r_kill, w_kill_next;
  logic          r_buf_v, w_buf_v_next;
  logic [31:0]   r_buf_pc, w_buf_pc_next;
  logic          r_misalign, w_mis_set;

  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_target_mis;
  logic [31:0] w_pc_plus4;
  logic        w_take;
  logic [31:0] w_take_pc;
  logic        w_take_mis;
  logic        w_flush;
  logic        w_fetch_en;

  pc_sequencer_npc_calc u_npc_calc (
    .i_pc       (r_pc),
    .i_npcop    (ex_npcop_i),
    .i_ex_pc    (ex_pc_i),
    .i_ex_imm   (ex_imm_i),
    .i_ex_alu   (ex_alu_i),
    .o_target   (w_target),
    .o_redirect (w_redirect),
    .o_misalign (w_target_mis)
  );

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_kill_next   = r_kill;
    w_buf_v_next  = r_buf_v;
    w_buf_pc_next = r_buf_pc;
    w_mis_set     = 1'b0;
    w_flush       = 1'b0;
    w_fetch_en    = 1'b1;
    w_take        = 1'b0;
    w_take_pc     = w_target;
    w_take_mis    = 1'b0;

    unique case (r_state)
      // RUN and WAIT share rules; WAIT only records that the fetch is pending.
      PCS_RUN, PCS_WAIT: begin
        if (w_redirect) begin
          w_take     = 1'b1;
          w_take_mis = w_target_mis;
        end else if (stall_i) begin
          w_state_next = PCS_STALL;
        end else if (!imem_rdy_i) begin
          w_state_next = PCS_WAIT;
        end else begin
          w_pc_next    = w_pc_plus4;
          w_state_next = PCS_RUN;
        end
      end

      PCS_STALL: begin
        w_fetch_en = 1'b0;
        if (stall_i) begin
          // Keep the first redirect only; anything after it in EX is wrong-path.
          if (w_redirect && !r_buf_v) begin
            w_buf_v_next  = 1'b1;
            w_buf_pc_next = w_target;
            w_mis_set     = w_target_mis;
          end
        end else if (r_buf_v) begin
          w_take       = 1'b1;
          w_take_pc    = r_buf_pc;
          w_buf_v_next = 1'b0;
        end else if (w_redirect) begin
          w_take     = 1'b1;
          w_take_mis = w_target_mis;
        end else begin
          w_state_next = PCS_RUN;
        end
      end

      PCS_REDIR: begin
        // New-path fetch proceeds; redirects seen here are bubbles and ignored.
        w_flush = 1'b1;
        if (imem_rdy_i && !stall_i) begin
          w_pc_next = w_pc_plus4;
        end
        if (r_kill <= KW'(1)) begin
          w_kill_next  = '0;
          w_state_next = PCS_RUN;
        end else begin
          w_kill_next = r_kill - KW'(1);
        end
      end
    endcase

    if (w_take) begin
      w_pc_next    = w_take_pc;
      w_flush      = 1'b1;
      w_mis_set    = w_take_mis;
      w_kill_next  = KILL_LOAD;
      w_state_next = AFTER_TAKE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= PCS_RUN;
      r_pc       <= RESET_PC;
      r_kill     <= '0;
      r_buf_v    <= 1'b0;
      r_buf_pc   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_kill     <= w_kill_next;
      r_buf_v    <= w_buf_v_next;
      r_buf_pc   <= w_buf_pc_next;
      r_misalign <= r_misalign | w_mis_set;
    end
  end

  assign pc_o         = r_pc;
  assign fetch_en_o   = w_fetch_en;
  // Flushes are combinational; reset must override a redirect on the inputs.
  assign flush_ifid_o = w_flush & rstn;
  assign flush_idex_o = w_flush & rstn;
  assign misalign_o   = r_misalign;
  assign state_o      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          KILL_DEPTH = 2;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall_i = 1'b0;
  logic        imem_rdy_i = 1'b1;
  logic [2:0]  ex_npcop_i = OP_PLUS4;
  logic [31:0] ex_pc_i = '0;
  logic [31:0] ex_imm_i = '0;
  logic [31:0] ex_alu_i = '0;
  logic [31:0] pc_o;
  logic        fetch_en_o;
  logic        flush_ifid_o;
  logic        flush_idex_o;
  logic        misalign_o;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_PC(RESET_PC), .KILL_DEPTH(KILL_DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall_i      (stall_i),
    .imem_rdy_i   (imem_rdy_i),
    .ex_npcop_i   (ex_npcop_i),
    .ex_pc_i      (ex_pc_i),
    .ex_imm_i     (ex_imm_i),
    .ex_alu_i     (ex_alu_i),
    .pc_o         (pc_o),
    .fetch_en_o   (fetch_en_o),
    .flush_ifid_o (flush_ifid_o),
    .flush_idex_o (flush_idex_o),
    .misalign_o   (misalign_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pipeline modes: kill slots pending, frozen by a stall, or fetching
  // (waiting only matters for the reported state code).
  logic [31:0] m_pc;
  int          m_kill;
  bit          m_stalled, m_waiting, m_buf_v, m_mis;
  logic [31:0] m_buf;

  task automatic model_reset();
    m_pc = RESET_PC; m_kill = 0; m_stalled = 0; m_waiting = 0;
    m_buf_v = 0; m_buf = '0; m_mis = 0;
  endtask

  function automatic void target_of(input logic [31:0] pc, input logic [2:0] op,
                                    input logic [31:0] epc, input logic [31:0] imm,
                                    input logic [31:0] alu, output bit red,
                                    output logic [31:0] t, output bit mis);
    logic [31:0] raw;
    raw = pc + 32'd4;
    red = 0;
    if (op == OP_BRANCH || op == OP_JUMP) begin raw = epc + imm; red = 1; end
    else if (op == OP_JALR) begin raw = alu & 32'hFFFF_FFFE; red = 1; end
    t   = raw & 32'hFFFF_FFFC;
    mis = red && raw[1];
  endfunction

  initial model_reset();
  always @(negedge rstn) model_reset();

  always @(negedge clk) begin
    int e_state;
    bit red, tmis, take, take_mis, e_flush;
    logic [31:0] t, take_pc, n_pc;
    if (!rstn) begin
      model_reset();
      chk("rst_pc", pc_o, RESET_PC);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_fetch_en", 32'(fetch_en_o), 32'd1);
      chk("rst_flush", 32'({flush_ifid_o, flush_idex_o}), 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
    end else begin
      e_state = (m_kill > 0) ? 3 : (m_stalled ? 2 : (m_waiting ? 1 : 0));
      chk("pc", pc_o, m_pc);
      chk("state", 32'(state_o), 32'(e_state));
      chk("fetch_en", 32'(fetch_en_o), 32'(e_state != 2));
      chk("misalign", 32'(misalign_o), 32'(m_mis));
      target_of(m_pc, ex_npcop_i, ex_pc_i, ex_imm_i, ex_alu_i, red, t, tmis);
      take = 0; take_pc = t; take_mis = 0; e_flush = 0; n_pc = m_pc;
      if (m_kill > 0) begin
        e_flush = 1;
        if (imem_rdy_i && !stall_i) n_pc = m_pc + 32'd4;
        m_kill--;
      end else if (m_stalled) begin
        if (stall_i) begin
          if (red && !m_buf_v) begin m_buf_v = 1; m_buf = t; if (tmis) m_mis = 1; end
        end else if (m_buf_v) begin
          take = 1; take_pc = m_buf; m_buf_v = 0;
        end else if (red) begin
          take = 1; take_mis = tmis;
        end else m_stalled = 0;
      end else begin
        if (red) begin take = 1; take_mis = tmis; end
        else if (stall_i) begin m_stalled = 1; m_waiting = 0; end
        else if (!imem_rdy_i) m_waiting = 1;
        else begin n_pc = m_pc + 32'd4; m_waiting = 0; end
      end
      if (take) begin
        n_pc = take_pc; e_flush = 1; m_kill = KILL_DEPTH - 1;
        m_stalled = 0; m_waiting = 0;
        if (take_mis) m_mis = 1;
      end
      chk("flush_ifid", 32'(flush_ifid_o), 32'(e_flush));
      chk("flush_idex", 32'(flush_idex_o), 32'(e_flush));
      m_pc = n_pc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic r, input logic [2:0] op,
                      input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] alu);
    @(posedge clk); #1;
    stall_i = s; imem_rdy_i = r; ex_npcop_i = op;
    ex_pc_i = epc; ex_imm_i = imm; ex_alu_i = alu;
    @(negedge clk); #1;
  endtask

  task automatic run1();
    step(1'b0, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int r;
    #1 rstn = 1'b0;
    // 1: reset and sequential fetch
    @(negedge clk); #1;
    chk("lit_rst_pc", pc_o, 32'h0);
    chk("lit_rst_flush", 32'(flush_ifid_o), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk); #1;
    chk("lit_pc0", pc_o, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      run1();
      chk("lit_seq_pc", pc_o, 32'(4 * k));
      chk("lit_seq_flush", 32'(flush_idex_o), 32'd0);
    end
    // 2: branch and jalr
    run1(); run1(); run1();
    step(1'b0, 1'b1, OP_BRANCH, 32'h18, 32'h10, 32'h0);
    chk("lit_br_pc", pc_o, 32'h20);
    chk("lit_br_flush0", 32'(flush_ifid_o), 32'd1);
    run1();
    chk("lit_br_target", pc_o, 32'h28);
    chk("lit_br_flush1", 32'(flush_idex_o), 32'd1);
    chk("lit_br_state", 32'(state_o), 32'd3);
    run1();
    chk("lit_br_run", 32'(state_o), 32'd0);
    chk("lit_br_flush2", 32'(flush_ifid_o), 32'd0);
    step(1'b0, 1'b1, OP_JALR, 32'h0, 32'h0, 32'h101);
    run1();
    chk("lit_jalr_pc", pc_o, 32'h100);
    chk("lit_jalr_mis", 32'(misalign_o), 32'd0);
    // 3: stall with buffered jump
    step(1'b0, 1'b1, OP_JUMP, 32'h0, 32'h3C, 32'h0);
    run1();
    step(1'b1, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    chk("lit_st_pc", pc_o, 32'h40);
    step(1'b1, 1'b1, OP_JUMP, 32'h30, 32'h100, 32'h0);
    chk("lit_st_fen", 32'(fetch_en_o), 32'd0);
    chk("lit_st_noflush", 32'(flush_ifid_o), 32'd0);
    step(1'b1, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    chk("lit_st_hold", pc_o, 32'h40);
    run1();
    chk("lit_st_release_flush", 32'(flush_idex_o), 32'd1);
    run1();
    chk("lit_st_target", pc_o, 32'h130);
    // 4: imem wait, redirect during wait
    step(1'b0, 1'b1, OP_JUMP, 32'h0, 32'h4, 32'h0);
    run1();
    step(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    chk("lit_wait_state", 32'(state_o), 32'd1);
    chk("lit_wait_pc", pc_o, 32'h8);
    run1();
    run1();
    chk("lit_wait_done", pc_o, 32'hC);
    step(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, OP_JUMP, 32'h100, 32'h100, 32'h0);
    run1();
    chk("lit_wait_redir", pc_o, 32'h200);
    // 5: wrap-around and misaligned branch
    run1();
    step(1'b0, 1'b1, OP_JUMP, 32'h0, 32'hFFFF_FFF8, 32'h0);
    run1(); run1();
    chk("lit_wrap_top", pc_o, 32'hFFFF_FFFC);
    run1();
    chk("lit_wrap_zero", pc_o, 32'h0);
    step(1'b0, 1'b1, OP_BRANCH, 32'h2, 32'h4, 32'h0);
    run1();
    chk("lit_mis_pc", pc_o, 32'h4);
    chk("lit_mis_set", 32'(misalign_o), 32'd1);
    run1(); run1();
    chk("lit_mis_sticky", 32'(misalign_o), 32'd1);
    // 6: reset mid-REDIR and mid-STALL
    step(1'b0, 1'b1, OP_JUMP, 32'h0, 32'h500, 32'h0);
    run1();
    ex_npcop_i = OP_JALR;
    #1 rstn = 1'b0;
    #1;
    chk("lit_rr_pc", pc_o, RESET_PC);
    chk("lit_rr_flush", 32'({flush_ifid_o, flush_idex_o}), 32'd0);
    chk("lit_rr_mis", 32'(misalign_o), 32'd0);
    @(posedge clk); #1 rstn = 1'b1; ex_npcop_i = OP_PLUS4;
    step(1'b1, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, OP_JUMP, 32'h0, 32'h700, 32'h0);
    #1 rstn = 1'b0;
    #1;
    chk("lit_rs_state", 32'(state_o), 32'd0);
    chk("lit_rs_fen", 32'(fetch_en_o), 32'd1);
    @(posedge clk); #1 rstn = 1'b1;
    stall_i = 1'b0; ex_npcop_i = OP_PLUS4;
    @(negedge clk); #1;
    chk("lit_rs_nobuf_flush", 32'(flush_ifid_o), 32'd0);
    run1();
    chk("lit_rs_nobuf_pc", pc_o, 32'h4);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rstn       = ($urandom_range(0, 249) != 0);
      stall_i    = ($urandom_range(0, 99) < 15);
      imem_rdy_i = ($urandom_range(0, 99) < 80);
      r = $urandom_range(0, 11);
      if (r <= 6)       ex_npcop_i = OP_PLUS4;
      else if (r == 7)  ex_npcop_i = OP_BRANCH;
      else if (r == 8)  ex_npcop_i = OP_JUMP;
      else if (r == 9)  ex_npcop_i = OP_JALR;
      else              ex_npcop_i = 3'($urandom_range(3, 7));
      ex_pc_i  = $urandom;
      ex_imm_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
      ex_alu_i = $urandom;
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
